// File: rtl/uart_device_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS/CTRL field
// positions, divisor floor and serialiser state encodings.
package uart_device_pkg;

   localparam logic [1:0] RegRxData = 2'd0;
   localparam logic [1:0] RegTxData = 2'd1;
   localparam logic [1:0] RegStatus = 2'd2;
   localparam logic [1:0] RegCtrl   = 2'd3;

   localparam int unsigned StRxValid = 0;
   localparam int unsigned StRxFull  = 1;
   localparam int unsigned StTxFull  = 2;
   localparam int unsigned StTxEmpty = 3;
   localparam int unsigned StTxBusy  = 4;
   localparam int unsigned StRxOvr   = 5;
   localparam int unsigned StFrmErr  = 6;
   localparam int unsigned StTxOvf   = 7;

   localparam int unsigned CtrlRxIe = 16;
   localparam logic [15:0] MinDiv   = 16'd16;

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   function automatic logic [15:0] clamp_div(input logic [15:0] div);
      return (div < MinDiv) ? MinDiv : div;
   endfunction

endpackage

// File: rtl/uart_device_if.sv
// Single-word strobe/rw/byte-enable device bus between the core and a responder.
interface uart_device_if #(
   parameter int unsigned XLEN = 32
);
   logic              strobe;
   logic [XLEN-1:0]   addr;
   logic              rw;
   logic [XLEN/8-1:0] byte_enable;
   logic [XLEN-1:0]   wdata;
   logic              data_ready;
   logic [XLEN-1:0]   rdata;

   modport master (
      output strobe, addr, rw, byte_enable, wdata,
      input  data_ready, rdata
   );

   modport slave (
      input  strobe, addr, rw, byte_enable, wdata,
      output data_ready, rdata
   );
endinterface

// File: rtl/uart_device_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module uart_device_sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [Width-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [Width-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(Depth):0] count_o
);
   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [PtrW:0]    count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (PtrW+1)'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_device.sv
// 8N1 UART responder on the uncached device port: bus decode, registered response, CSRs,
// TX/RX FIFOs and the bit-level serialiser/deserialiser.
module uart_device
   import uart_device_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DEF_DIV    = 434
) (
   input  logic         clk_i,
   input  logic         rst_i,
   uart_device_if.slave s_device,
   output logic         uart_tx_o,
   input  logic         uart_rx_i,
   output logic         irq_o
);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]      reg_sel;
   logic            rd_rx, wr_tx, wr_status, wr_ctrl;
   logic [XLEN-1:0] rdata;
   logic [7:0]      status;
   logic            ready_q;
   logic [XLEN-1:0] rdata_q;

   logic [15:0] div_q, div_d;
   logic        rx_ie_q, rx_ie_d;
   logic        rx_ovr_q, rx_ovr_d, frm_err_q, frm_err_d, tx_ovf_q, tx_ovf_d;
   logic        rx_ovr_evt, frm_err_evt, tx_ovf_evt;

   logic            tx_pop, tx_full, tx_empty;
   logic [7:0]      tx_rdata;
   logic [CntW-1:0] unused_tx_count;
   logic            rx_push, rx_full, rx_empty;
   logic [7:0]      rx_rdata;
   logic [CntW-1:0] unused_rx_count;
   logic            unused_bus;

   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_line_q, tx_line_d, tx_bit_end;

   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [1:0]  rx_sync_q;
   logic        rx_prev_q, rx_s, rx_bit_end;

   assign unused_bus = ^{s_device.addr[XLEN-1:4], s_device.addr[1:0],
                         s_device.wdata[XLEN-1:17], s_device.byte_enable[XLEN/8-1:3]};

   assign reg_sel   = s_device.addr[3:2];
   assign rd_rx     = s_device.strobe & ~s_device.rw & (reg_sel == RegRxData);
   assign wr_tx     = s_device.strobe & s_device.rw & (reg_sel == RegTxData)
                      & s_device.byte_enable[0];
   assign wr_status = s_device.strobe & s_device.rw & (reg_sel == RegStatus)
                      & s_device.byte_enable[0];
   assign wr_ctrl   = s_device.strobe & s_device.rw & (reg_sel == RegCtrl);

   assign status = {tx_ovf_q, frm_err_q, rx_ovr_q, (tx_state_q != TxIdle),
                    tx_empty, tx_full, rx_full, ~rx_empty};

   always_comb begin
      rdata = '0;
      case (reg_sel)
         RegRxData: begin
            if (rx_empty) rdata[XLEN-1] = 1'b1;
            else          rdata[7:0]    = rx_rdata;
         end
         RegStatus: rdata[7:0] = status;
         RegCtrl:   rdata      = XLEN'({rx_ie_q, div_q});
         default:   rdata      = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= s_device.strobe;
         rdata_q <= (s_device.strobe & ~s_device.rw) ? rdata : '0;
      end
   end

   assign s_device.data_ready = ready_q;
   assign s_device.rdata      = rdata_q;
   assign irq_o               = rx_ie_q & ~rx_empty;
   assign uart_tx_o           = tx_line_q;

   // A push into a full FIFO still lands when the opposite side pops in the same cycle.
   assign tx_ovf_evt = wr_tx & tx_full & ~tx_pop;
   assign rx_ovr_evt = rx_push & rx_full & ~rd_rx;

   always_comb begin
      div_d   = div_q;
      rx_ie_d = rx_ie_q;
      if (wr_ctrl) begin
         if (s_device.byte_enable[0]) div_d[7:0]  = s_device.wdata[7:0];
         if (s_device.byte_enable[1]) div_d[15:8] = s_device.wdata[15:8];
         if (s_device.byte_enable[0] | s_device.byte_enable[1]) div_d = clamp_div(div_d);
         if (s_device.byte_enable[2]) rx_ie_d = s_device.wdata[CtrlRxIe];
      end
      rx_ovr_d  = (rx_ovr_q & ~(wr_status & s_device.wdata[StRxOvr])) | rx_ovr_evt;
      frm_err_d = (frm_err_q & ~(wr_status & s_device.wdata[StFrmErr])) | frm_err_evt;
      tx_ovf_d  = (tx_ovf_q & ~(wr_status & s_device.wdata[StTxOvf])) | tx_ovf_evt;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         div_q     <= 16'(DEF_DIV);
         rx_ie_q   <= 1'b0;
         rx_ovr_q  <= 1'b0;
         frm_err_q <= 1'b0;
         tx_ovf_q  <= 1'b0;
      end else begin
         div_q     <= div_d;
         rx_ie_q   <= rx_ie_d;
         rx_ovr_q  <= rx_ovr_d;
         frm_err_q <= frm_err_d;
         tx_ovf_q  <= tx_ovf_d;
      end
   end

   uart_device_sync_fifo #(.Width(8), .Depth(FIFO_DEPTH)) u_tx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_i),
      .push_i  (wr_tx),
      .wdata_i (s_device.wdata[7:0]),
      .pop_i   (tx_pop),
      .rdata_o (tx_rdata),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (unused_tx_count)
   );

   uart_device_sync_fifo #(.Width(8), .Depth(FIFO_DEPTH)) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_i),
      .push_i  (rx_push),
      .wdata_i (rx_shift_q),
      .pop_i   (rd_rx),
      .rdata_o (rx_rdata),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .count_o (unused_rx_count)
   );

   assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 16'd1;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_line_d  = tx_line_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TxIdle: begin
            tx_cnt_d = '0;
            if (!tx_empty) begin
               tx_state_d = TxStart;
               tx_pop     = 1'b1;
               tx_shift_d = tx_rdata;
               tx_div_d   = div_q;
               tx_line_d  = 1'b0;
            end
         end
         TxStart: begin
            if (tx_bit_end) begin
               tx_state_d = TxData;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_line_d  = tx_shift_q[0];
            end
         end
         TxData: begin
            if (tx_bit_end) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TxStop;
                  tx_line_d  = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = tx_shift_q >> 1;
                  tx_line_d  = tx_shift_q[1];
               end
            end
         end
         TxStop: begin
            if (tx_bit_end) begin
               tx_state_d = TxIdle;
               tx_cnt_d   = '0;
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_div_q   <= 16'(DEF_DIV);
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_line_q  <= tx_line_d;
      end
   end

   assign rx_s       = rx_sync_q[1];
   assign rx_bit_end = (rx_cnt_q == rx_div_q - 16'd1);

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q + 16'd1;
      rx_div_d    = rx_div_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_push     = 1'b0;
      frm_err_evt = 1'b0;
      case (rx_state_q)
         RxIdle: begin
            rx_cnt_d = '0;
            if (rx_prev_q & ~rx_s) begin
               rx_state_d = RxStart;
               rx_div_d   = div_q;
            end
         end
         RxStart: begin
            // Mid-start re-check rejects glitches shorter than half a bit.
            if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (rx_bit_end) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RxStop;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end
         end
         RxStop: begin
            if (rx_bit_end) begin
               rx_cnt_d    = '0;
               rx_state_d  = RxIdle;
               rx_push     = rx_s;
               frm_err_evt = ~rx_s;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rx_sync_q  <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_div_q   <= 16'(DEF_DIV);
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_sync_q  <= {rx_sync_q[0], uart_rx_i};
         rx_prev_q  <= rx_s;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

endmodule

// File: tb/tb_uart_device.sv
// Self-checking bench for uart_device: register vector table, directed serial sequences and a
// randomized phase scored against queue-based models of the line and the FIFOs.
module tb_uart_device;
   localparam int Div = 16;

   typedef struct {
      logic        rw;
      logic [1:0]  regi;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_line = 1'b1;
   logic tx_line, irq;
   int   checks = 0;
   int   errors = 0;

   uart_device_if #(.XLEN(32)) dev_if ();

   uart_device #(.XLEN(32), .FIFO_DEPTH(16), .DEF_DIV(434)) dut (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .s_device  (dev_if),
      .uart_tx_o (tx_line),
      .uart_rx_i (rx_line),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
      end
   endtask

   task automatic bus(input logic rw, input logic [1:0] regi, input logic [3:0] be,
                      input logic [31:0] wdata, output logic [31:0] rdata);
      @(negedge clk);
      check("no_pulse_without_strobe", {31'b0, dev_if.data_ready}, 32'd0);
      dev_if.strobe      = 1'b1;
      dev_if.rw          = rw;
      dev_if.addr        = {28'hC000000, regi, 2'b00};
      dev_if.byte_enable = be;
      dev_if.wdata       = wdata;
      @(negedge clk);
      dev_if.strobe = 1'b0;
      check("data_ready_pulse", {31'b0, dev_if.data_ready}, 32'd1);
      rdata = dev_if.rdata;
   endtask

   task automatic rd(input logic [1:0] regi, output logic [31:0] d);
      bus(1'b0, regi, 4'h0, 32'h0, d);
   endtask

   task automatic wr(input logic [1:0] regi, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] dummy;
      bus(1'b1, regi, be, d, dummy);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx_line = 1'b0;
      repeat (Div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         repeat (Div) @(negedge clk);
      end
      rx_line = stop;
      repeat (Div) @(negedge clk);
      rx_line = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Sample every clock of one frame and compare with the ideal 8N1 waveform.
   task automatic expect_frame(input logic [7:0] b, input string name);
      int k, bad;
      logic e;
      k = 0;
      while (tx_line !== 1'b0 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check({name, "_start_seen"}, {31'b0, (k < 2000)}, 32'd1);
      bad = 0;
      for (int j = 0; j < 10 * Div; j++) begin
         if (j < Div)           e = 1'b0;
         else if (j < 9 * Div)  e = b[(j - Div) / Div];
         else                   e = 1'b1;
         if (tx_line !== e) bad++;
         @(negedge clk);
      end
      check({name, "_waveform_bad_samples"}, bad, 0);
   endtask

   // Line monitor: decodes every frame at bit centres into mon_q.
   logic [7:0] mon_q[$];
   logic [7:0] mon_b;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && tx_line === 1'b0) begin
            repeat (Div + Div / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               mon_b[i] = tx_line;
               if (i < 7) repeat (Div) @(negedge clk);
            end
            repeat (Div) @(negedge clk);
            mon_q.push_back(mon_b);
         end
      end
   end

   vec_t        vecs[17];
   logic [31:0] d;
   logic [7:0]  tx_exp[$];
   logic [7:0]  rx_m[$];
   logic [2:0]  sticky_m;
   logic [15:0] div_m;
   logic        ie_m;

   initial begin
      dev_if.strobe      = 1'b0;
      dev_if.rw          = 1'b0;
      dev_if.addr        = '0;
      dev_if.byte_enable = '0;
      dev_if.wdata       = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_tx_high", {31'b0, tx_line}, 32'd1);
      check("reset_irq_low", {31'b0, irq}, 32'd0);
      check("reset_ready_low", {31'b0, dev_if.data_ready}, 32'd0);
      check("reset_rdata_zero", dev_if.rdata, 32'd0);
      rst_n = 1'b1;

      // Register vector table
      vecs[0]  = '{1'b0, 2'd2, 4'h0, 32'h0,         32'h0000_0008};
      vecs[1]  = '{1'b0, 2'd3, 4'h0, 32'h0,         32'h0000_01B2};
      vecs[2]  = '{1'b0, 2'd0, 4'h0, 32'h0,         32'h8000_0000};
      vecs[3]  = '{1'b0, 2'd1, 4'h0, 32'h0,         32'h0000_0000};
      vecs[4]  = '{1'b1, 2'd3, 4'hF, 32'h0001_0005, 32'h0};
      vecs[5]  = '{1'b0, 2'd3, 4'h0, 32'h0,         32'h0001_0010};
      vecs[6]  = '{1'b1, 2'd3, 4'h2, 32'h0000_0300, 32'h0};
      vecs[7]  = '{1'b0, 2'd3, 4'h0, 32'h0,         32'h0001_0310};
      vecs[8]  = '{1'b1, 2'd3, 4'h4, 32'h0000_0000, 32'h0};
      vecs[9]  = '{1'b0, 2'd3, 4'h0, 32'h0,         32'h0000_0310};
      vecs[10] = '{1'b1, 2'd0, 4'hF, 32'h0000_0055, 32'h0};
      vecs[11] = '{1'b1, 2'd2, 4'hF, 32'h0000_00FF, 32'h0};
      vecs[12] = '{1'b0, 2'd2, 4'h0, 32'h0,         32'h0000_0008};
      vecs[13] = '{1'b1, 2'd3, 4'h1, 32'h0000_0008, 32'h0};
      vecs[14] = '{1'b1, 2'd3, 4'h2, 32'h0000_0000, 32'h0};
      vecs[15] = '{1'b0, 2'd3, 4'h0, 32'h0,         32'h0000_0010};
      vecs[16] = '{1'b0, 2'd0, 4'h0, 32'h0,         32'h8000_0000};
      for (int i = 0; i < 17; i++) begin
         bus(vecs[i].rw, vecs[i].regi, vecs[i].be, vecs[i].wdata, d);
         if (!vecs[i].rw) check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
      end

      // Back-to-back strobes: one pulse each, never in the strobe cycle
      @(negedge clk);
      dev_if.strobe = 1'b1; dev_if.rw = 1'b0; dev_if.addr = 32'hC000_0008;
      #1 check("b2b_not_same_cycle", {31'b0, dev_if.data_ready}, 32'd0);
      @(negedge clk);
      check("b2b_first_ready", {31'b0, dev_if.data_ready}, 32'd1);
      check("b2b_first_status", dev_if.rdata, 32'h0000_0008);
      dev_if.addr = 32'hC000_000C;
      @(negedge clk);
      dev_if.strobe = 1'b0;
      check("b2b_second_ready", {31'b0, dev_if.data_ready}, 32'd1);
      check("b2b_second_ctrl", dev_if.rdata, 32'h0000_0010);
      @(negedge clk);
      check("b2b_pulse_ends", {31'b0, dev_if.data_ready}, 32'd0);
      check("b2b_rdata_idle_zero", dev_if.rdata, 32'd0);

      // Single TX frame, exact waveform at div 16
      wr(2'd1, 4'h1, 32'h0000_00A5);
      expect_frame(8'hA5, "tx_a5");
      repeat (10) @(negedge clk);
      rd(2'd2, d);
      check("tx_a5_done_status", d, 32'h0000_0008);
      mon_q.delete();

      // Full TX: the serialiser takes byte 0 at once, 16 more fill the FIFO, the 18th drops
      for (int i = 0; i < 18; i++) wr(2'd1, 4'h1, 32'h10 + i);
      rd(2'd2, d);
      check("tx_full_status", d, 32'h0000_0094);
      for (int t = 0; t < 5000 && mon_q.size() < 17; t++) @(negedge clk);
      check("tx_full_frame_count", mon_q.size(), 17);
      for (int i = 0; i < 17 && i < mon_q.size(); i++)
         check($sformatf("tx_full_byte%0d", i), {24'b0, mon_q[i]}, 32'h10 + i);
      repeat (20) @(negedge clk);
      rd(2'd2, d);
      check("tx_drained_status", d, 32'h0000_0088);
      wr(2'd2, 4'h1, 32'h0000_0080);
      rd(2'd2, d);
      check("tx_ovf_cleared", d, 32'h0000_0008);
      mon_q.delete();

      // RX with interrupt
      wr(2'd3, 4'hF, 32'h0001_0010);
      send_rx(8'h3C, 1'b1);
      check("rx_irq_set", {31'b0, irq}, 32'd1);
      rd(2'd0, d);
      check("rx_3c", d, 32'h0000_003C);
      rd(2'd0, d);
      check("rx_empty_read", d, 32'h8000_0000);
      check("rx_irq_clear", {31'b0, irq}, 32'd0);

      // Framing error, overrun, W1C of all sticky bits
      send_rx(8'h77, 1'b0);
      rd(2'd2, d);
      check("frm_err_status", d, 32'h0000_0048);
      for (int i = 0; i < 17; i++) send_rx(8'(i * 7 + 1), 1'b1);
      rd(2'd2, d);
      check("rx_ovr_status", d, 32'h0000_006B);
      wr(2'd2, 4'h1, 32'h0000_00E0);
      rd(2'd2, d);
      check("sticky_w1c", d, 32'h0000_000B);
      for (int i = 0; i < 16; i++) begin
         rd(2'd0, d);
         check($sformatf("rx_ovr_byte%0d", i), d, 32'(i * 7 + 1));
      end
      rd(2'd0, d);
      check("rx_ovr_drained", d, 32'h8000_0000);

      // Randomized traffic against queue models
      sticky_m = 3'b000;
      for (int it = 0; it < 40; it++) begin
         int op;
         op = $urandom_range(0, 5);
         if (op <= 1) begin
            if (tx_exp.size() - mon_q.size() < 8) begin
               logic [7:0] b;
               b = 8'($urandom);
               tx_exp.push_back(b);
               wr(2'd1, 4'h1, {24'b0, b});
            end
         end else if (op == 2) begin
            logic [7:0] b;
            logic       stop;
            b = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_rx(b, stop);
            if (!stop)                 sticky_m[1] = 1'b1;
            else if (rx_m.size() < 16) rx_m.push_back(b);
            else                       sticky_m[0] = 1'b1;
         end else if (op == 3) begin
            rd(2'd0, d);
            if (rx_m.size() == 0) check("rnd_rxdata", d, 32'h8000_0000);
            else                  check("rnd_rxdata", d, {24'b0, rx_m.pop_front()});
            check("rnd_irq", {31'b0, irq}, {31'b0, (rx_m.size() != 0)});
         end else if (op == 4) begin
            rd(2'd2, d);
            check("rnd_status", d & 32'hE3,
                  {24'b0, sticky_m, 3'b0, (rx_m.size() == 16), (rx_m.size() != 0)});
         end else begin
            logic [7:0] v;
            v = 8'($urandom);
            wr(2'd2, 4'h1, {24'b0, v});
            sticky_m = sticky_m & ~v[7:5];
         end
      end
      while (rx_m.size() != 0) begin
         rd(2'd0, d);
         check("rnd_rx_drain", d, {24'b0, rx_m.pop_front()});
      end
      for (int t = 0; t < 5000 && mon_q.size() < tx_exp.size(); t++) @(negedge clk);
      check("rnd_tx_count", mon_q.size(), tx_exp.size());
      for (int i = 0; i < tx_exp.size() && i < mon_q.size(); i++)
         check($sformatf("rnd_tx_byte%0d", i), {24'b0, mon_q[i]}, {24'b0, tx_exp[i]});
      repeat (20) @(negedge clk);

      // Randomized CTRL lanes and divisor floor
      div_m = 16'h0010;
      ie_m  = 1'b1;
      for (int it = 0; it < 24; it++) begin
         logic [31:0] v;
         logic [3:0]  be;
         v  = $urandom;
         if (it % 3 == 0) v[15:4] = 12'h0;
         be = 4'($urandom);
         wr(2'd3, be, v);
         if (be[0]) div_m[7:0]  = v[7:0];
         if (be[1]) div_m[15:8] = v[15:8];
         if ((be[0] || be[1]) && div_m < 16) div_m = 16;
         if (be[2]) ie_m = v[16];
         rd(2'd3, d);
         check("rnd_ctrl", d, {15'b0, ie_m, div_m});
      end
      wr(2'd3, 4'hF, 32'h0001_0010);

      // Reset in the middle of a TX frame
      send_rx(8'h5A, 1'b1);
      check("pre_reset_irq", {31'b0, irq}, 32'd1);
      wr(2'd1, 4'h1, 32'h0000_0000);
      repeat (40) @(negedge clk);
      check("pre_reset_tx_low", {31'b0, tx_line}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset_tx_high", {31'b0, tx_line}, 32'd1);
      check("mid_reset_irq_low", {31'b0, irq}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rd(2'd2, d);
      check("post_reset_status", d, 32'h0000_0008);
      rd(2'd3, d);
      check("post_reset_ctrl", d, 32'h0000_01B2);
      rd(2'd0, d);
      check("post_reset_rx_empty", d, 32'h8000_0000);
      repeat (30) @(negedge clk);
      check("post_reset_tx_idle", {31'b0, tx_line}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
